// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan receiver: waits for each multiplexed active-low pattern to settle, then decodes it to BCD per digit.
// Latency: STABLE_CYCLES edges from first sample to digits. No backpressure; the bus is sampled every cycle.
// Optional commit watchdog (stale output) is built only when SEVENSEG_SCAN_TIMEOUT_EN is defined.
module sevenseg_scan_decoder #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [6:0]            a_to_g,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  stale
);

  localparam int              SW          = DIGITS + 7;
  localparam logic [7:0]      STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]      STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [DIGITS-1:0] ONE       = DIGITS'(1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sevenseg_scan_decoder: illegal STABLE_CYCLES or TIMEOUT_CYCLES");
  end

  logic [SW-1:0]     r_s_in;
  logic [SW-1:0]     r_s_prev;
  logic [7:0]        r_cnt;
  logic [DIGITS-1:0] r_seen;

  logic [SW-1:0]     w_sample;
  logic              w_same;
  logic              w_stable;
  logic [DIGITS-1:0] w_an_low;
  logic              w_an_legal;
  logic              w_commit;
  logic [DIGITS-1:0] w_commit_mask;
  logic [DIGITS-1:0] w_seen_acc;
  logic [4:0]        w_dec;
  logic              w_to_fire;

  function automatic logic [4:0] decode7(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = 5'h00;
      7'b1001111: res = 5'h01;
      7'b0010010: res = 5'h02;
      7'b0000110: res = 5'h03;
      7'b1001100: res = 5'h04;
      7'b0100100: res = 5'h05;
      7'b0100000: res = 5'h06;
      7'b0001111: res = 5'h07;
      7'b0000000: res = 5'h08;
      7'b0000100: res = 5'h09;
      default:    res = 5'h1F;
    endcase
    return res;
  endfunction

  // w_same looks one sample ahead, so r_cnt is already 0 whenever r_s_in != r_s_prev
  // and the commit lands exactly STABLE_CYCLES edges after the new value is first registered.
  assign w_sample      = {an, a_to_g};
  assign w_same        = (w_sample == r_s_in);
  assign w_stable      = (r_s_in == r_s_prev);
  assign w_an_low      = ~r_s_in[SW-1:7];
  assign w_an_legal    = (w_an_low != '0) && ((w_an_low & (w_an_low - ONE)) == '0);
  assign w_commit      = w_same && w_stable && (r_cnt == STABLE_LAST) && w_an_legal;
  assign w_commit_mask = w_commit ? w_an_low : '0;
  assign w_seen_acc    = r_seen | w_commit_mask;
  assign w_dec         = decode7(r_s_in[6:0]);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s_in   <= '0;
      r_s_prev <= '0;
      r_cnt    <= '0;
    end else begin
      r_s_in   <= w_sample;
      r_s_prev <= r_s_in;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != STABLE_MAX)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      digits    <= '0;
      digit_err <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (w_commit_mask[i]) begin
          digits[4*i +: 4] <= w_dec[3:0];
          digit_err[i]     <= w_dec[4];
        end
      end
    end
  end

  // The completing commit's bit is absorbed into the finished frame, never carried forward.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_seen      <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (w_seen_acc == '1) begin
        frame_valid <= 1'b1;
        r_seen      <= '0;
      end else if (w_to_fire) begin
        r_seen <= '0;
      end else begin
        r_seen <= w_seen_acc;
      end
    end
  end

`ifdef SEVENSEG_SCAN_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_stale;

  assign w_to_fire = !w_commit && (r_to_cnt == TO_LAST);
  assign stale     = r_stale;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (w_commit) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else begin
      if (r_to_cnt != TO_MAX)
        r_to_cnt <= r_to_cnt + TO_ONE;
      if (w_to_fire)
        r_stale <= 1'b1;
    end
  end
`else
  assign w_to_fire = 1'b0;
  assign stale     = 1'b0;
`endif

endmodule
